// File: rtl/i2s_pkg.sv
// Shared definitions for the multi-lane I2S receiver: data alignment modes,
// the lock-state encoding and the slot counter width helper.
package i2s_pkg;

    // Data alignment relative to the WS edge
    localparam int MODE_I2S = 0;   // MSB one BCLK after the WS edge
    localparam int MODE_LJ  = 1;   // MSB on the WS edge (left-justified)

    // Lock tracking: IDLE records a first WS sample, HUNT waits for a WS edge,
    // LOCKED counts slot positions and checks slot lengths
    typedef enum logic [1:0] {
        LOCK_IDLE,
        LOCK_HUNT,
        LOCK_LOCKED
    } lockState_t;

    // Bits needed to count positions 0..slots-1
    function automatic int cntWidth(input int slots);
        return (slots > 2) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/i2s_rx_multi_if.sv
// Frame output bus of the I2S receiver: a wide data word plus valid/ready.
interface i2s_rx_multi_if #(
    parameter int NUM_LANES  = 2,
    parameter int DATA_WIDTH = 24
);
    logic [2*NUM_LANES*DATA_WIDTH-1:0] frame_data;
    logic                              frame_valid;
    logic                              frame_ready;

    modport master (
        output frame_data,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/i2s_lane_cap.sv
// Per-lane capture: shifts in slot bits MSB-first and keeps the finished
// left and right words. The right word is presented straight from the shift
// path on the cycle it completes so the frame register can load it at once.
module i2s_lane_cap #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  shiftEn_i,
    input  logic                  bit_i,
    input  logic                  storeLeft_i,
    input  logic                  storeRight_i,
    output logic [DATA_WIDTH-1:0] leftWord_o,
    output logic [DATA_WIDTH-1:0] rightWord_o
);

    logic [DATA_WIDTH-2:0] shift_q;
    logic [DATA_WIDTH-1:0] shiftNext;
    logic [DATA_WIDTH-1:0] leftHold_q;
    logic [DATA_WIDTH-1:0] rightHold_q;

    assign shiftNext = {shift_q, bit_i};

    // Shift register and holding registers; a word is stored together with its last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            leftHold_q  <= '0;
            rightHold_q <= '0;
        end else begin
            if (flush_i) begin
                shift_q <= '0;
            end else if (shiftEn_i) begin
                shift_q <= shiftNext[DATA_WIDTH-2:0];
            end
            if (storeLeft_i) begin
                leftHold_q <= shiftNext;
            end
            if (storeRight_i) begin
                rightHold_q <= shiftNext;
            end
        end
    end

    assign leftWord_o  = leftHold_q;
    assign rightWord_o = storeRight_i ? shiftNext : rightHold_q;

endmodule

// File: rtl/i2s_rx_multi.sv
// Multi-lane I2S receiver: synchronizes BCLK/WS/SDATA into the system clock,
// tracks slot positions, checks slot lengths, assembles left/right pairs from
// every lane into one frame and hands it out over a valid/ready bus.
module i2s_rx_multi
    import i2s_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int MODE       = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bclk,
    input  logic                 ws,
    input  logic [NUM_LANES-1:0] sdata,
    input  logic                 enable,
    input  logic                 clear_flags,
    i2s_rx_multi_if.master       frame_if,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int DELAY   = (MODE == MODE_I2S) ? 1 : 0;
    localparam int CNT_W   = cntWidth(SLOT_WIDTH);
    localparam int POS_W   = CNT_W + 1;
    localparam int FRAME_W = 2 * NUM_LANES * DATA_WIDTH;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SLOT_WIDTH - 1);
    localparam logic [POS_W-1:0] FIRST_POS = POS_W'(DELAY);
    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(DELAY + DATA_WIDTH - 1);
    localparam logic [POS_W-1:0] WORD_LEN  = POS_W'(DATA_WIDTH);

    logic [1:0]           bclkSync_q;
    logic                 bclkDly_q;
    logic [1:0]           wsSync_q;
    logic [NUM_LANES-1:0] sdataMeta_q;
    logic [NUM_LANES-1:0] sdataSync_q;
    logic                 bclkRise;
    logic                 wsNow;
    logic                 wsChange;

    lockState_t           lockState_q, lockState_d;
    logic [CNT_W-1:0]     slotCnt_q, slotCnt_d;
    logic                 wsPrev_q, wsPrev_d;
    logic                 leftDone_q, leftDone_d;

    logic                 slotStart;
    logic                 slotRun;
    logic                 slotErr;
    logic [POS_W-1:0]     bitPos;
    logic                 capture;
    logic                 lastBit;
    logic                 storeLeft;
    logic                 storeRight;
    logic                 frameDone;

    logic [FRAME_W-1:0]   nextFrame;
    logic [FRAME_W-1:0]   frameData_q, frameData_d;
    logic                 frameValid_q, frameValid_d;
    logic                 overrun_q, overrun_d;
    logic                 frameErr_q, frameErr_d;

    // Two-stage synchronizers for all I2S inputs plus a delayed BCLK for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclkSync_q  <= '0;
            bclkDly_q   <= 1'b0;
            wsSync_q    <= '0;
            sdataMeta_q <= '0;
            sdataSync_q <= '0;
        end else begin
            bclkSync_q  <= {bclkSync_q[0], bclk};
            bclkDly_q   <= bclkSync_q[1];
            wsSync_q    <= {wsSync_q[0], ws};
            sdataMeta_q <= sdata;
            sdataSync_q <= sdataMeta_q;
        end
    end

    assign bclkRise = bclkSync_q[1] & ~bclkDly_q;
    assign wsNow    = wsSync_q[1];
    assign wsChange = (wsNow != wsPrev_q);

    // Lock state, slot counter, last WS sample and left-slot-complete flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockState_q <= LOCK_IDLE;
            slotCnt_q   <= '0;
            wsPrev_q    <= 1'b0;
            leftDone_q  <= 1'b0;
        end else begin
            lockState_q <= lockState_d;
            slotCnt_q   <= slotCnt_d;
            wsPrev_q    <= wsPrev_d;
            leftDone_q  <= leftDone_d;
        end
    end

    // Slot tracking on each BCLK rise: lock, count, length check, bit position decode
    always_comb begin
        lockState_d = lockState_q;
        slotCnt_d   = slotCnt_q;
        wsPrev_d    = wsPrev_q;
        leftDone_d  = leftDone_q;
        slotStart   = 1'b0;
        slotRun     = 1'b0;
        slotErr     = 1'b0;

        if (!enable) begin
            lockState_d = LOCK_IDLE;
            slotCnt_d   = '0;
            leftDone_d  = 1'b0;
        end else if (bclkRise) begin
            wsPrev_d = wsNow;
            unique case (lockState_q)
                LOCK_IDLE: begin
                    lockState_d = LOCK_HUNT;
                end
                LOCK_HUNT: begin
                    if (wsChange) begin
                        lockState_d = LOCK_LOCKED;
                        slotCnt_d   = '0;
                        slotStart   = 1'b1;
                        leftDone_d  = 1'b0;
                    end
                end
                LOCK_LOCKED: begin
                    if (wsChange) begin
                        slotCnt_d = '0;
                        slotStart = 1'b1;
                        if (slotCnt_q != CNT_MAX) begin
                            slotErr    = 1'b1;
                            leftDone_d = 1'b0;
                        end else if (!wsNow) begin
                            leftDone_d = 1'b0;
                        end
                    end else if (slotCnt_q == CNT_MAX) begin
                        slotErr     = 1'b1;
                        lockState_d = LOCK_HUNT;
                        slotCnt_d   = '0;
                        leftDone_d  = 1'b0;
                    end else begin
                        slotCnt_d = slotCnt_q + CNT_W'(1);
                        slotRun   = 1'b1;
                    end
                end
                default: begin
                    lockState_d = LOCK_IDLE;
                end
            endcase
        end

        bitPos     = slotStart ? '0 : (POS_W'(slotCnt_q) + POS_W'(1));
        capture    = (slotStart || slotRun) && (POS_W'(bitPos - FIRST_POS) < WORD_LEN);
        lastBit    = capture && (bitPos == LAST_POS);
        storeLeft  = lastBit && !wsNow;
        storeRight = lastBit && wsNow;
        frameDone  = storeRight && leftDone_q;

        if (storeLeft) begin
            leftDone_d = 1'b1;
        end
        if (frameDone) begin
            leftDone_d = 1'b0;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
        logic [DATA_WIDTH-1:0] leftWord;
        logic [DATA_WIDTH-1:0] rightWord;

        i2s_lane_cap #(
            .DATA_WIDTH(DATA_WIDTH)
        ) uCap (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (!enable),
            .shiftEn_i   (capture),
            .bit_i       (sdataSync_q[l]),
            .storeLeft_i (storeLeft),
            .storeRight_i(storeRight),
            .leftWord_o  (leftWord),
            .rightWord_o (rightWord)
        );

        assign nextFrame[(2*l)*DATA_WIDTH   +: DATA_WIDTH] = leftWord;
        assign nextFrame[(2*l+1)*DATA_WIDTH +: DATA_WIDTH] = rightWord;
    end

    // Output handshake and sticky flags; a set on the same cycle wins over clear
    always_comb begin
        frameData_d  = frameData_q;
        frameValid_d = frameValid_q;
        overrun_d    = overrun_q;
        frameErr_d   = frameErr_q;

        if (clear_flags) begin
            overrun_d  = 1'b0;
            frameErr_d = 1'b0;
        end

        if (frameDone && (!frameValid_q || frame_if.frame_ready)) begin
            frameData_d  = nextFrame;
            frameValid_d = 1'b1;
        end else begin
            if (frameValid_q && frame_if.frame_ready) begin
                frameValid_d = 1'b0;
            end
            if (frameDone) begin
                overrun_d = 1'b1;
            end
        end

        if (slotErr) begin
            frameErr_d = 1'b1;
        end
    end

    // Output register and flag state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameData_q  <= '0;
            frameValid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frameErr_q   <= 1'b0;
        end else begin
            frameData_q  <= frameData_d;
            frameValid_q <= frameValid_d;
            overrun_q    <= overrun_d;
            frameErr_q   <= frameErr_d;
        end
    end

    assign frame_if.frame_data  = frameData_q;
    assign frame_if.frame_valid = frameValid_q;
    assign overrun              = overrun_q;
    assign frame_err            = frameErr_q;

endmodule

// File: tb/tb_i2s_rx_multi.sv
// Testbench for i2s_rx_multi: one instance in I2S mode and one in
// left-justified mode, each fed with randomized half-frame sequences and
// compared against a half-frame level reference model.
module tb_i2s_rx_multi;
    import i2s_pkg::*;

    localparam int LANES = 2;
    localparam int DW    = 24;
    localparam int SW    = 32;
    localparam int FW    = 2 * LANES * DW;
    localparam int HALF  = 40;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             clearFlags = 1'b0;
    logic             bclk0 = 1'b0, ws0 = 1'b0;
    logic             bclk1 = 1'b0, ws1 = 1'b0;
    logic [LANES-1:0] sdata0 = '0, sdata1 = '0;
    logic             overrun0, frameErr0, overrun1, frameErr1;

    i2s_rx_multi_if #(.NUM_LANES(LANES), .DATA_WIDTH(DW)) bus0 ();
    i2s_rx_multi_if #(.NUM_LANES(LANES), .DATA_WIDTH(DW)) bus1 ();

    i2s_rx_multi #(
        .NUM_LANES(LANES), .DATA_WIDTH(DW), .SLOT_WIDTH(SW), .MODE(MODE_I2S)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bclk(bclk0), .ws(ws0), .sdata(sdata0),
        .enable(enable), .clear_flags(clearFlags), .frame_if(bus0),
        .overrun(overrun0), .frame_err(frameErr0)
    );

    i2s_rx_multi #(
        .NUM_LANES(LANES), .DATA_WIDTH(DW), .SLOT_WIDTH(SW), .MODE(MODE_LJ)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bclk(bclk1), .ws(ws1), .sdata(sdata1),
        .enable(enable), .clear_flags(clearFlags), .frame_if(bus1),
        .overrun(overrun1), .frame_err(frameErr1)
    );

    // System clock at 8x the bit clock
    always #5 clk = ~clk;

    // Half-frame description table and reference results
    int              hfCount;
    int              hfLen [16];
    logic            hfWs  [16];
    logic [DW-1:0]   hfWord[16][LANES];
    logic [FW-1:0]   modelQ[$];
    logic [FW-1:0]   exp0[$], exp1[$];
    logic [FW-1:0]   firstFrame0, firstFrame1;
    int              got0 = 0, got1 = 0, pulses0 = 0, pulses1 = 0;
    int              total = 0, bad = 0;

    localparam logic [FW-1:0] SPEC_FRAME = {24'h7FFFFF, 24'h800001, 24'hABCDEF, 24'h123456};

    task automatic checkOutput(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Accepted frames are compared in order against the expected queues
    always @(negedge clk) begin
        if (bus0.frame_valid) pulses0++;
        if (bus1.frame_valid) pulses1++;
        if (bus0.frame_valid && bus0.frame_ready) begin
            if (got0 == 0) firstFrame0 = bus0.frame_data;
            if (exp0.size() > 0) checkOutput("frame dut0", bus0.frame_data, exp0.pop_front());
            got0++;
        end
        if (bus1.frame_valid && bus1.frame_ready) begin
            if (got1 == 0) firstFrame1 = bus1.frame_data;
            if (exp1.size() > 0) checkOutput("frame dut1", bus1.frame_data, exp1.pop_front());
            got1++;
        end
    end

    // Alternating right/left half-frames of nominal length with random words
    task automatic makeSeq(input int n);
        hfCount = n;
        for (int i = 0; i < n; i++) begin
            hfWs[i]  = (i % 2 == 0);
            hfLen[i] = SW;
            for (int l = 0; l < LANES; l++) hfWord[i][l] = DW'($urandom);
        end
    endtask

    // Reference: half-frame 0 only establishes the WS level; a frame is a
    // full-length left half-frame followed by a right half-frame long enough
    // to carry all its data bits
    task automatic modelFrames(input int delay);
        logic [FW-1:0] f;
        modelQ.delete();
        for (int i = 1; i + 1 < hfCount; i++) begin
            if (!hfWs[i] && hfWs[i+1] && hfLen[i] == SW && hfLen[i+1] >= delay + DW) begin
                for (int l = 0; l < LANES; l++) begin
                    f[(2*l)*DW   +: DW] = hfWord[i][l];
                    f[(2*l+1)*DW +: DW] = hfWord[i+1][l];
                end
                modelQ.push_back(f);
            end
        end
    endtask

    task automatic driveBit(input int mode, input logic w, input logic [LANES-1:0] b);
        if (mode == MODE_I2S) begin bclk0 = 1'b0; ws0 = w; sdata0 = b; end
        else                  begin bclk1 = 1'b0; ws1 = w; sdata1 = b; end
        #HALF;
        if (mode == MODE_I2S) bclk0 = 1'b1; else bclk1 = 1'b1;
        #HALF;
    endtask

    // Serializes the table; abortAt >= 0 pulls reset before that bit is sent
    task automatic applyStimulus(input int mode, input int abortAt);
        int               delay;
        int               bitNum;
        int               p;
        logic [LANES-1:0] bits;
        delay  = (mode == MODE_I2S) ? 1 : 0;
        bitNum = 0;
        for (int i = 0; i < hfCount; i++) begin
            for (int k = 0; k < hfLen[i]; k++) begin
                p = k - delay;
                for (int l = 0; l < LANES; l++)
                    bits[l] = (p >= 0 && p < DW) ? hfWord[i][l][DW-1-p] : 1'($urandom);
                if (bitNum == abortAt) begin
                    rst_n = 1'b0;
                    return;
                end
                driveBit(mode, hfWs[i], bits);
                bitNum++;
            end
        end
    endtask

    task automatic restartCapture();
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulseClear();
        clearFlags = 1'b1;
        @(negedge clk);
        clearFlags = 1'b0;
        @(negedge clk);
    endtask

    task automatic loadSpecWords();
        hfWord[1][0] = 24'h123456; hfWord[2][0] = 24'hABCDEF;
        hfWord[1][1] = 24'h800001; hfWord[2][1] = 24'h7FFFFF;
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        bus0.frame_ready = 1'b1;
        bus1.frame_ready = 1'b1;
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset data0",  bus0.frame_data, '0);
        checkOutput("reset valid0", FW'(bus0.frame_valid), '0);
        checkOutput("reset ovr0",   FW'(overrun0), '0);
        checkOutput("reset err0",   FW'(frameErr0), '0);
        checkOutput("reset data1",  bus1.frame_data, '0);
        checkOutput("reset valid1", FW'(bus1.frame_valid), '0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // I2S mode, ready high: spec words first, then random frames
        makeSeq(7);
        loadSpecWords();
        modelFrames(1);
        n = modelQ.size();
        foreach (modelQ[i]) exp0.push_back(modelQ[i]);
        got0 = 0; pulses0 = 0;
        applyStimulus(MODE_I2S, -1);
        repeat (20) @(negedge clk);
        checkOutput("i2s first frame", firstFrame0, SPEC_FRAME);
        checkOutput("i2s frame count", FW'(got0), FW'(n));
        checkOutput("i2s valid pulses", FW'(pulses0), FW'(n));
        checkOutput("i2s frame err", FW'(frameErr0), '0);
        checkOutput("i2s overrun", FW'(overrun0), '0);

        // Left-justified mode, same spec words
        makeSeq(7);
        loadSpecWords();
        modelFrames(0);
        n = modelQ.size();
        foreach (modelQ[i]) exp1.push_back(modelQ[i]);
        got1 = 0; pulses1 = 0;
        applyStimulus(MODE_LJ, -1);
        repeat (20) @(negedge clk);
        checkOutput("lj first frame", firstFrame1, SPEC_FRAME);
        checkOutput("lj frame count", FW'(got1), FW'(n));
        checkOutput("lj valid pulses", FW'(pulses1), FW'(n));
        checkOutput("lj frame err", FW'(frameErr1), '0);

        // Overrun: ready low for three frames holds the first one
        restartCapture();
        bus0.frame_ready = 1'b0;
        makeSeq(7);
        modelFrames(1);
        got0 = 0;
        applyStimulus(MODE_I2S, -1);
        repeat (20) @(negedge clk);
        checkOutput("ovr held valid", FW'(bus0.frame_valid), FW'(1));
        checkOutput("ovr held data", bus0.frame_data, modelQ[0]);
        checkOutput("ovr flag set", FW'(overrun0), FW'(1));
        pulseClear();
        checkOutput("ovr flag cleared", FW'(overrun0), '0);
        exp0.push_back(modelQ[0]);
        bus0.frame_ready = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("ovr accepted count", FW'(got0), FW'(1));
        checkOutput("ovr valid dropped", FW'(bus0.frame_valid), '0);

        // Short left half-frame: that frame is lost, the next one arrives
        restartCapture();
        makeSeq(7);
        hfLen[3] = 30;
        modelFrames(1);
        n = modelQ.size();
        foreach (modelQ[i]) exp0.push_back(modelQ[i]);
        got0 = 0;
        applyStimulus(MODE_I2S, -1);
        repeat (20) @(negedge clk);
        checkOutput("short frame count", FW'(got0), FW'(n));
        checkOutput("short frame err", FW'(frameErr0), FW'(1));
        checkOutput("short queue empty", FW'(exp0.size()), '0);
        pulseClear();
        checkOutput("short err cleared", FW'(frameErr0), '0);

        // Reset in the middle of a right slot while a frame is held
        restartCapture();
        bus0.frame_ready = 1'b0;
        makeSeq(5);
        applyStimulus(MODE_I2S, 4 * SW + 10);
        repeat (3) @(negedge clk);
        checkOutput("midrst data", bus0.frame_data, '0);
        checkOutput("midrst valid", FW'(bus0.frame_valid), '0);
        checkOutput("midrst ovr", FW'(overrun0), '0);
        checkOutput("midrst err", FW'(frameErr0), '0);
        bus0.frame_ready = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        makeSeq(5);
        modelFrames(1);
        n = modelQ.size();
        foreach (modelQ[i]) exp0.push_back(modelQ[i]);
        got0 = 0;
        applyStimulus(MODE_I2S, -1);
        repeat (20) @(negedge clk);
        checkOutput("midrst frame count", FW'(got0), FW'(n));
        checkOutput("midrst frame err", FW'(frameErr0), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
